// File: rtl/floppy_pkg.sv
// Shared constants and loader state encoding for the Disk II nibble-track loader.
package floppy_pkg;

  localparam int TRACK_BYTES  = 6312;
  localparam int NUM_TRACKS   = 35;
  localparam int SECTOR_BYTES = 512;
  localparam int RAM_AW       = 13;

  // Base value that no real track start can equal, so nothing hits after reset.
  localparam logic [17:0] BASE_INVALID = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOCATE,
    SETUP,
    REQ,
    XFER,
    READY
  } loader_state_t;

endpackage

// File: rtl/floppy_track_ram.sv
// Simple dual-port track buffer: SD side writes, controller side reads with one registered stage.
module floppy_track_ram #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // NOTE: neither the array nor rdata is reset, so this maps onto block RAM; the reader gates rdata with its own valid flag.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/floppy_track_loader.sv
// Fetches the nibble track holding FLOPPY_ADDRESS from the SD image into a local buffer and serves bytes from it.
module floppy_track_loader
  import floppy_pkg::*;
#(
  parameter int          TRACK_BYTES = floppy_pkg::TRACK_BYTES,
  parameter int          NUM_TRACKS  = floppy_pkg::NUM_TRACKS,
  parameter logic [31:0] LBA_BASE    = 32'd0
) (
  input  logic        PH_2,
  input  logic        RESET_N,
  input  logic [17:0] FLOPPY_ADDRESS,
  output logic [7:0]  FLOPPY_DATA_IN,
  output logic        TRACK_READY,
  input  logic        IMG_MOUNTED,
  output logic [31:0] SD_LBA,
  output logic        SD_RD,
  input  logic        SD_ACK,
  input  logic [8:0]  SD_BUFF_ADDR,
  input  logic [7:0]  SD_BUFF_DOUT,
  input  logic        SD_BUFF_WR
);

  loader_state_t state;
  logic [17:0]   cur_base, new_base, acc;
  logic [5:0]    trk;
  logic [8:0]    skip;
  logic [3:0]    nsec, k;
  logic          loaded, aborting, ack_d, hit_q;
  logic [7:0]    ram_q;

  logic [17:0]   rel, win_rel;
  logic [18:0]   acc_next;
  logic [13:0]   idx, r;
  logic [3:0]    nsec_w;
  logic          miss, win_miss, hit, ack_fall, wr_en;

  // NOTE: every signal gets a value on every pass through this block, so no latch can be inferred.
  always_comb begin
    rel      = FLOPPY_ADDRESS - cur_base;
    win_rel  = FLOPPY_ADDRESS - new_base;
    miss     = (FLOPPY_ADDRESS < cur_base) || (rel >= 18'(TRACK_BYTES));
    win_miss = (FLOPPY_ADDRESS < new_base) || (win_rel >= 18'(TRACK_BYTES));
    hit      = TRACK_READY && loaded && !miss;
    acc_next = {1'b0, acc} + 19'(TRACK_BYTES);
    ack_fall = ack_d && !SD_ACK;
    nsec_w   = 4'((14'(new_base[8:0]) + 14'(TRACK_BYTES + SECTOR_BYTES - 1)) >> 9);
    // Position within the multi-sector span, then shifted back by the leading bytes of the first sector.
    idx      = {1'b0, k, 9'b0} + 14'(SD_BUFF_ADDR);
    r        = idx - 14'(skip);
    wr_en    = (state == XFER) && SD_ACK && SD_BUFF_WR && !aborting && IMG_MOUNTED &&
               (idx >= 14'(skip)) && (r < 14'(TRACK_BYTES));
  end

  floppy_track_ram #(.AW(RAM_AW)) u_ram (
    .clk   (PH_2),
    .we    (wr_en),
    .waddr (r[RAM_AW-1:0]),
    .wdata (SD_BUFF_DOUT),
    .raddr (rel[RAM_AW-1:0]),
    .rdata (ram_q)
  );

  assign FLOPPY_DATA_IN = hit_q ? ram_q : 8'h00;

  always_ff @(posedge PH_2 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      cur_base    <= BASE_INVALID;
      new_base    <= '0;
      acc         <= '0;
      trk         <= '0;
      skip        <= '0;
      nsec        <= '0;
      k           <= '0;
      loaded      <= 1'b0;
      aborting    <= 1'b0;
      ack_d       <= 1'b0;
      hit_q       <= 1'b0;
      TRACK_READY <= 1'b0;
      SD_RD       <= 1'b0;
      SD_LBA      <= '0;
    end else begin
      ack_d <= SD_ACK;
      hit_q <= hit;
      case (state)
        IDLE: begin
          TRACK_READY <= 1'b0;
          SD_RD       <= 1'b0;
          loaded      <= 1'b0;
          cur_base    <= BASE_INVALID;
          if (IMG_MOUNTED) begin
            acc   <= '0;
            trk   <= '0;
            state <= LOCATE;
          end
        end
        READY: begin
          if (!IMG_MOUNTED) begin
            TRACK_READY <= 1'b0;
            state       <= IDLE;
          end else if (miss) begin
            TRACK_READY <= 1'b0;
            acc         <= '0;
            trk         <= '0;
            state       <= LOCATE;
          end
        end
        LOCATE: begin
          if (!IMG_MOUNTED) begin
            state <= IDLE;
          end else if ({1'b0, FLOPPY_ADDRESS} >= acc_next) begin
            acc <= acc_next[17:0];
            trk <= trk + 6'd1;
          end else begin
            new_base <= acc;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (!IMG_MOUNTED) begin
            state <= IDLE;
          end else if (int'(trk) >= NUM_TRACKS) begin
            // Past the end of the image: present an empty track that reads as zero.
            cur_base    <= new_base;
            loaded      <= 1'b0;
            TRACK_READY <= 1'b1;
            state       <= READY;
          end else begin
            skip   <= new_base[8:0];
            SD_LBA <= LBA_BASE + 32'(new_base[17:9]);
            nsec   <= nsec_w;
            k      <= '0;
            loaded <= 1'b0;
            state  <= REQ;
          end
        end
        REQ: begin
          if (!IMG_MOUNTED) begin
            SD_RD <= 1'b0;
            if (SD_ACK) begin
              aborting <= 1'b1;
              state    <= XFER;
            end else begin
              state <= IDLE;
            end
          end else if (!SD_RD) begin
            if (!SD_ACK) SD_RD <= 1'b1;
          end else if (SD_ACK) begin
            SD_RD <= 1'b0;
            state <= XFER;
          end
        end
        XFER: begin
          if (!IMG_MOUNTED) aborting <= 1'b1;
          if (ack_fall) begin
            k      <= k + 4'd1;
            SD_LBA <= SD_LBA + 32'd1;
            if (aborting || !IMG_MOUNTED) begin
              aborting <= 1'b0;
              state    <= IDLE;
            end else if (win_miss) begin
              acc   <= '0;
              trk   <= '0;
              state <= LOCATE;
            end else if (k + 4'd1 == nsec) begin
              cur_base    <= new_base;
              loaded      <= 1'b1;
              TRACK_READY <= 1'b1;
              state       <= READY;
            end else begin
              state <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floppy_track_loader.sv
// Directed bench for floppy_track_loader with a behavioural SD sector source.
module tb_floppy_track_loader;

  logic        PH_2;
  logic        RESET_N;
  logic [17:0] FLOPPY_ADDRESS;
  logic [7:0]  FLOPPY_DATA_IN;
  logic        TRACK_READY;
  logic        IMG_MOUNTED;
  logic [31:0] SD_LBA;
  logic        SD_RD;
  logic        SD_ACK;
  logic [8:0]  SD_BUFF_ADDR;
  logic [7:0]  SD_BUFF_DOUT;
  logic        SD_BUFF_WR;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ack_falls = 0;
  int          bad_rd = 0;
  int          snap;
  logic        rd_prev = 1'b0;
  logic [31:0] req_lba[$];

  floppy_track_loader dut (
    .PH_2           (PH_2),
    .RESET_N        (RESET_N),
    .FLOPPY_ADDRESS (FLOPPY_ADDRESS),
    .FLOPPY_DATA_IN (FLOPPY_DATA_IN),
    .TRACK_READY    (TRACK_READY),
    .IMG_MOUNTED    (IMG_MOUNTED),
    .SD_LBA         (SD_LBA),
    .SD_RD          (SD_RD),
    .SD_ACK         (SD_ACK),
    .SD_BUFF_ADDR   (SD_BUFF_ADDR),
    .SD_BUFF_DOUT   (SD_BUFF_DOUT),
    .SD_BUFF_WR     (SD_BUFF_WR)
  );

  initial PH_2 = 1'b0;
  always #5 PH_2 = ~PH_2;

  // Image content; the sector number term exposes LBA mix-ups.
  function automatic logic [7:0] img_byte(input int a);
    return 8'(a * 13 + (a >> 9) + 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [17:0] a, input logic [7:0] exp);
    FLOPPY_ADDRESS = a;
    @(negedge PH_2);
    check(tag, FLOPPY_DATA_IN, exp);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int c = 0;
    while (!TRACK_READY && c < budget) begin
      @(negedge PH_2);
      c++;
    end
    check(tag, TRACK_READY, 1);
  endtask

  task automatic wait_sector(input string tag, input int n, input int budget);
    int c = 0;
    while (!(req_lba.size() >= n && SD_ACK) && c < budget) begin
      @(negedge PH_2);
      c++;
    end
    check(tag, 32'((req_lba.size() >= n) && SD_ACK), 1);
  endtask

  // SD source: one sector per request, a data byte every cycle while ACK is high.
  initial begin
    logic [31:0] lba;
    SD_ACK = 1'b0;
    SD_BUFF_WR = 1'b0;
    SD_BUFF_ADDR = '0;
    SD_BUFF_DOUT = '0;
    forever begin
      @(negedge PH_2);
      if (SD_RD && !SD_ACK) begin
        lba = SD_LBA;
        req_lba.push_back(lba);
        SD_ACK = 1'b1;
        for (int i = 0; i < 512; i++) begin
          @(negedge PH_2);
          SD_BUFF_WR   = 1'b1;
          SD_BUFF_ADDR = 9'(i);
          SD_BUFF_DOUT = img_byte(int'(lba) * 512 + i);
        end
        @(negedge PH_2);
        SD_BUFF_WR = 1'b0;
        SD_ACK     = 1'b0;
        ack_falls++;
      end
    end
  end

  // Flags any request edge raised while a transfer is still acknowledged.
  initial begin
    forever begin
      @(posedge PH_2);
      #1;
      if (SD_RD && !rd_prev && SD_ACK) bad_rd++;
      rd_prev = SD_RD;
    end
  end

  initial begin
    RESET_N = 1'b0;
    IMG_MOUNTED = 1'b0;
    FLOPPY_ADDRESS = 18'd5;
    repeat (3) @(negedge PH_2);
    check("rst_data", FLOPPY_DATA_IN, 0);
    check("rst_ready", TRACK_READY, 0);
    check("rst_rd", SD_RD, 0);
    check("rst_lba", SD_LBA, 0);
    RESET_N = 1'b1;
    @(negedge PH_2);

    // Track 0 load
    snap = ack_falls;
    IMG_MOUNTED = 1'b1;
    wait_ready("t0_ready", 20000);
    check("t0_acks_at_ready", 32'(ack_falls - snap), 13);
    check("t0_nreq", 32'(req_lba.size()), 13);
    check("t0_first_lba", req_lba[0], 0);
    check("t0_last_lba", req_lba[12], 12);
    @(negedge PH_2);
    check("t0_byte5", FLOPPY_DATA_IN, img_byte(5));
    FLOPPY_ADDRESS = 18'd100;
    #1;
    check("t0_latency_old", FLOPPY_DATA_IN, img_byte(5));
    @(negedge PH_2);
    check("t0_latency_new", FLOPPY_DATA_IN, img_byte(100));
    read_check("t0_last_byte", 18'd6311, img_byte(6311));

    // Track 3, unaligned start inside LBA 36
    req_lba.delete();
    FLOPPY_ADDRESS = 18'd18946;
    @(negedge PH_2);
    check("t3_miss_ready", TRACK_READY, 0);
    check("t3_miss_data", FLOPPY_DATA_IN, 0);
    wait_ready("t3_ready", 20000);
    check("t3_nreq", 32'(req_lba.size()), 14);
    check("t3_first_lba", req_lba[0], 36);
    check("t3_last_lba", req_lba[13], 49);
    @(negedge PH_2);
    check("t3_byte", FLOPPY_DATA_IN, img_byte(18946));
    read_check("t3_first_byte", 18'd18936, img_byte(18936));
    read_check("t3_last_byte", 18'd25247, img_byte(25247));

    // Head moves to track 1 while sector 5 of track 0 is in flight
    req_lba.delete();
    FLOPPY_ADDRESS = 18'd5;
    wait_sector("mv_sector5", 5, 20000);
    FLOPPY_ADDRESS = 18'd6319;
    wait_ready("mv_ready", 20000);
    check("mv_nreq_at_ready", 32'(req_lba.size()), 18);
    check("mv_sector5_lba", req_lba[4], 4);
    check("mv_reload_lba", req_lba[5], 12);
    check("mv_last_lba", req_lba[17], 24);
    @(negedge PH_2);
    check("mv_byte", FLOPPY_DATA_IN, img_byte(6319));

    // Track 36 lies past the image
    req_lba.delete();
    FLOPPY_ADDRESS = 18'd227232;
    wait_ready("oob_ready", 200);
    check("oob_nreq", 32'(req_lba.size()), 0);
    @(negedge PH_2);
    check("oob_data", FLOPPY_DATA_IN, 0);
    read_check("oob_data2", 18'd227300, 8'h00);

    // Image removed mid-transfer
    req_lba.delete();
    FLOPPY_ADDRESS = 18'd5;
    wait_sector("um_sector3", 3, 20000);
    IMG_MOUNTED = 1'b0;
    @(negedge PH_2);
    check("um_rd", SD_RD, 0);
    check("um_ready", TRACK_READY, 0);
    for (int c = 0; c < 600 && SD_ACK; c++) @(negedge PH_2);
    check("um_ack_fell", SD_ACK, 0);
    repeat (20) @(negedge PH_2);
    check("um_nreq_idle", 32'(req_lba.size()), 3);
    check("um_rd_idle", SD_RD, 0);
    IMG_MOUNTED = 1'b1;
    wait_ready("um_ready_again", 20000);
    check("um_nreq", 32'(req_lba.size()), 16);
    check("um_restart_lba", req_lba[3], 0);
    @(negedge PH_2);
    check("um_byte", FLOPPY_DATA_IN, img_byte(5));

    // Asynchronous reset during a transfer
    req_lba.delete();
    FLOPPY_ADDRESS = 18'd18946;
    wait_sector("rs_sector2", 2, 20000);
    RESET_N = 1'b0;
    #1;
    check("rs_ready", TRACK_READY, 0);
    check("rs_rd", SD_RD, 0);
    check("rs_lba", SD_LBA, 0);
    check("rs_data", FLOPPY_DATA_IN, 0);
    repeat (2) @(negedge PH_2);
    RESET_N = 1'b1;
    wait_ready("rs_ready_again", 20000);
    check("rs_nreq", 32'(req_lba.size()), 16);
    check("rs_restart_lba", req_lba[2], 36);
    @(negedge PH_2);
    check("rs_byte", FLOPPY_DATA_IN, img_byte(18946));

    check("rd_while_ack", 32'(bad_rd), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
